// File: rtl/bridge_rx_if.sv
// bridge_rx_if: byte-stream input and packet-stream output bundle of bridge_rx_parser
interface bridge_rx_if #(parameter int DEPTH = 256);
   logic [7:0]             rx_data;
   logic                   rx_valid;
   logic                   rx_frame_err;
   logic [7:0]             pkt_data;
   logic                   pkt_last;
   logic                   pkt_valid;
   logic                   pkt_ready;
   logic                   connected;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [7:0]             chk_err_cnt;
   logic [7:0]             drop_cnt;
   modport master (
      output rx_data, rx_valid, rx_frame_err, pkt_ready,
      input  pkt_data, pkt_last, pkt_valid, connected, fifo_count, chk_err_cnt, drop_cnt
   );
   modport slave (
      input  rx_data, rx_valid, rx_frame_err, pkt_ready,
      output pkt_data, pkt_last, pkt_valid, connected, fifo_count, chk_err_cnt, drop_cnt
   );
endinterface

// File: rtl/bridge_rx_parser.sv
// bridge_rx_parser: frames BD/LEN/PAYLOAD/CHK packets into a commit-on-good-checksum payload FIFO and tracks link liveness.
// Define BRIDGE_RX_STATS_EN to implement the chk_err_cnt/drop_cnt statistics counters (tied to zero otherwise).
module bridge_rx_parser #(
   parameter int CLK_FREQ     = 48_000_000,
   parameter int DEPTH        = 256,
   parameter int MAX_LEN      = 32,
   parameter int BYTE_TIMEOUT = 480,
   parameter int LINK_TIMEOUT = CLK_FREQ * 3
) (
   input logic        clk,
   input logic        rst_n,
   bridge_rx_if.slave bus
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(BYTE_TIMEOUT + 1);
   localparam int LW = $clog2(LINK_TIMEOUT + 1);
   localparam logic [7:0] SYNC = 8'hBD;
   typedef enum logic [1:0] {HUNT, LEN, PAY, CHK} state_t;
   state_t        state_q, state_d;
   logic [7:0]    rem_q, rem_d, sum_q, sum_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, spec_wr_ptr_q, spec_wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] fifo_count_q, fifo_count_d;
   logic [TW-1:0] byte_tmr_q, byte_tmr_d;
   logic [LW-1:0] link_cnt_q, link_cnt_d;
   logic          connected_q, connected_d;
   logic [8:0]    head_q, head_d;
   logic [8:0]    mem [DEPTH];
   logic          we, pop, abort, chk_inc, drp_inc;
   // parser FSM, speculative write pointer, registered FIFO head and link timer
   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      sum_d         = sum_q;
      wr_ptr_d      = wr_ptr_q;
      spec_wr_ptr_d = spec_wr_ptr_q;
      we            = 1'b0;
      chk_inc       = 1'b0;
      drp_inc       = 1'b0;
      pop           = fifo_count_q != '0 && bus.pkt_ready;
      rd_ptr_d      = rd_ptr_q + PW'(pop);
      fifo_count_d  = wr_ptr_q - rd_ptr_d;
      head_d        = mem[rd_ptr_d[PW-2:0]];
      byte_tmr_d    = (bus.rx_valid || state_q == HUNT) ? '0 : byte_tmr_q + 1'b1;
      link_cnt_d    = connected_q ? link_cnt_q + 1'b1 : link_cnt_q;
      connected_d   = connected_q && link_cnt_d != LW'(LINK_TIMEOUT);
      abort         = state_q != HUNT &&
                      (bus.rx_frame_err || (!bus.rx_valid && byte_tmr_q == TW'(BYTE_TIMEOUT - 1)));
      if (abort) begin
         spec_wr_ptr_d = wr_ptr_q;
         drp_inc       = 1'b1;
         state_d       = HUNT;
      end else if (bus.rx_valid) begin
         case (state_q)
            HUNT: state_d = bus.rx_data == SYNC ? LEN : HUNT;
            LEN: begin
               rem_d   = bus.rx_data;
               sum_d   = bus.rx_data;
               drp_inc = bus.rx_data == 8'd0 || bus.rx_data > 8'(MAX_LEN);
               state_d = drp_inc ? HUNT : PAY;
            end
            PAY: begin
               if (spec_wr_ptr_q - rd_ptr_q == PW'(DEPTH)) begin
                  spec_wr_ptr_d = wr_ptr_q;
                  drp_inc       = 1'b1;
                  state_d       = HUNT;
               end else begin
                  we            = 1'b1;
                  spec_wr_ptr_d = spec_wr_ptr_q + 1'b1;
                  sum_d         = sum_q + bus.rx_data;
                  rem_d         = rem_q - 1'b1;
                  state_d       = rem_q == 8'd1 ? CHK : PAY;
               end
            end
            CHK: begin
               if (bus.rx_data == sum_q) begin
                  wr_ptr_d    = spec_wr_ptr_q;
                  link_cnt_d  = '0;
                  connected_d = 1'b1;
               end else begin
                  spec_wr_ptr_d = wr_ptr_q;
                  chk_inc       = 1'b1;
               end
               state_d = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end
   end
   // state registers; reset discards all packet and FIFO state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         rem_q         <= '0;
         sum_q         <= '0;
         wr_ptr_q      <= '0;
         spec_wr_ptr_q <= '0;
         rd_ptr_q      <= '0;
         fifo_count_q  <= '0;
         byte_tmr_q    <= '0;
         link_cnt_q    <= '0;
         connected_q   <= 1'b0;
         head_q        <= '0;
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         sum_q         <= sum_d;
         wr_ptr_q      <= wr_ptr_d;
         spec_wr_ptr_q <= spec_wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_count_q  <= fifo_count_d;
         byte_tmr_q    <= byte_tmr_d;
         link_cnt_q    <= link_cnt_d;
         connected_q   <= connected_d;
         head_q        <= head_d;
      end
   end
   // payload storage, written speculatively ahead of the committed pointer
   always_ff @(posedge clk) begin
      if (we) mem[spec_wr_ptr_q[PW-2:0]] <= {rem_q == 8'd1, bus.rx_data};
   end
   assign bus.pkt_valid  = fifo_count_q != '0;
   assign bus.pkt_data   = bus.pkt_valid ? head_q[7:0] : 8'h00;
   assign bus.pkt_last   = bus.pkt_valid && head_q[8];
   assign bus.fifo_count = fifo_count_q;
   assign bus.connected  = connected_q;
`ifdef BRIDGE_RX_STATS_EN
   logic [7:0] chk_err_cnt_q, chk_err_cnt_d, drop_cnt_q, drop_cnt_d;
   // saturating error statistics
   always_comb begin
      chk_err_cnt_d = chk_err_cnt_q + 8'(chk_inc && chk_err_cnt_q != 8'hFF);
      drop_cnt_d    = drop_cnt_q + 8'(drp_inc && drop_cnt_q != 8'hFF);
   end
   // statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_err_cnt_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         chk_err_cnt_q <= chk_err_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end
   assign bus.chk_err_cnt = chk_err_cnt_q;
   assign bus.drop_cnt    = drop_cnt_q;
`else
   logic stats_unused;
   assign stats_unused    = chk_inc | drp_inc;
   assign bus.chk_err_cnt = 8'h00;
   assign bus.drop_cnt    = 8'h00;
`endif
endmodule
